// File: rtl/duty_ramp.sv
// Slew-limited fan duty controller.
// A kick-start applies full duty for a fixed number of ticks so that the fan
// overcomes static friction. After that, duty_out walks toward duty_target by
// at most STEP per tick, and holds once it gets there.
// All outputs are registered, so every response appears one clock after its cause.

module duty_ramp #(
    parameter int TICK_DIV   = 100_000,
    parameter int STEP       = 5,
    parameter int KICK_TICKS = 200,
    parameter int KICK_MIN   = 40
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       enable,
    input  logic [7:0] duty_target,
    output logic [7:0] duty_out,
    output logic       busy,
    output logic       kick_active
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int KW = (KICK_TICKS > 1) ? $clog2(KICK_TICKS) : 1;

    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [KW-1:0] KICK_LAST  = KW'(KICK_TICKS - 1);
    localparam logic [7:0]    KICK_MIN8  = 8'(KICK_MIN);
    localparam logic [8:0]    STEP9      = 9'(STEP);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_KICK = 2'd1,
        S_RAMP = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    state_t          state_r;
    logic [PW-1:0]   presc_r;
    logic [KW-1:0]   kick_cnt_r;
    logic            tick_s;
    logic [8:0]      duty9_s;
    logic [8:0]      targ9_s;
    logic [8:0]      diff9_s;
    logic [8:0]      step9_s;
    logic [7:0]      ramp_next_s;

    assign tick_s = (presc_r == PRESC_LAST);

    // Next ramp value: step toward the target by at most STEP, using 9-bit math so it cannot wrap.
    always_comb begin
        duty9_s     = {1'b0, duty_out};
        targ9_s     = {1'b0, duty_target};
        diff9_s     = 9'd0;
        step9_s     = 9'd0;
        ramp_next_s = duty_out;
        if (targ9_s > duty9_s) begin
            diff9_s     = targ9_s - duty9_s;
            step9_s     = (diff9_s < STEP9) ? diff9_s : STEP9;
            ramp_next_s = 8'(duty9_s + step9_s);
        end else if (targ9_s < duty9_s) begin
            diff9_s     = duty9_s - targ9_s;
            step9_s     = (diff9_s < STEP9) ? diff9_s : STEP9;
            ramp_next_s = 8'(duty9_s - step9_s);
        end else begin
            ramp_next_s = duty_out;
        end
    end

    // State machine, tick prescaler, kick counter and registered outputs.
    always_ff @(posedge clk) begin
        if (reset_p || !enable) begin
            state_r     <= S_OFF;
            presc_r     <= {PW{1'b0}};
            kick_cnt_r  <= {KW{1'b0}};
            duty_out    <= 8'd0;
            busy        <= 1'b0;
            kick_active <= 1'b0;
        end else begin
            case (state_r)
                S_OFF: begin
                    presc_r    <= {PW{1'b0}};
                    kick_cnt_r <= {KW{1'b0}};
                    if (duty_target >= KICK_MIN8) begin
                        state_r     <= S_KICK;
                        duty_out    <= 8'd255;
                        busy        <= 1'b1;
                        kick_active <= 1'b1;
                    end else if (duty_target != 8'd0) begin
                        state_r     <= S_RAMP;
                        duty_out    <= 8'd0;
                        busy        <= 1'b1;
                        kick_active <= 1'b0;
                    end else begin
                        state_r     <= S_OFF;
                        duty_out    <= 8'd0;
                        busy        <= 1'b0;
                        kick_active <= 1'b0;
                    end
                end
                S_KICK: begin
                    // A zero target cuts the kick short. Other retargets wait for the kick to finish.
                    if (duty_target == 8'd0 || (tick_s && kick_cnt_r == KICK_LAST)) begin
                        state_r     <= S_RAMP;
                        presc_r     <= {PW{1'b0}};
                        kick_cnt_r  <= {KW{1'b0}};
                        kick_active <= 1'b0;
                    end else if (tick_s) begin
                        presc_r    <= {PW{1'b0}};
                        kick_cnt_r <= kick_cnt_r + KW'(1);
                    end else begin
                        presc_r <= presc_r + PW'(1);
                    end
                end
                S_RAMP: begin
                    if (duty_out == duty_target) begin
                        state_r <= (duty_target != 8'd0) ? S_HOLD : S_OFF;
                        presc_r <= {PW{1'b0}};
                        busy    <= 1'b0;
                    end else if (tick_s) begin
                        presc_r  <= {PW{1'b0}};
                        duty_out <= ramp_next_s;
                    end else begin
                        presc_r <= presc_r + PW'(1);
                    end
                end
                S_HOLD: begin
                    // In hold, duty_out equals the old target, so any difference means the target moved.
                    presc_r <= {PW{1'b0}};
                    if (duty_target != duty_out) begin
                        state_r <= S_RAMP;
                        busy    <= 1'b1;
                    end else begin
                        state_r <= S_HOLD;
                    end
                end
                default: begin
                    state_r     <= S_OFF;
                    presc_r     <= {PW{1'b0}};
                    kick_cnt_r  <= {KW{1'b0}};
                    duty_out    <= 8'd0;
                    busy        <= 1'b0;
                    kick_active <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_duty_ramp.sv
// Self-checking bench for duty_ramp.
// Part 1 applies a table of directed vectors and checks each row's outcome against hand-derived constants.
// Part 2 applies random enable, target and reset stimulus.
// Every cycle, the DUT is also compared with a behavioural model. The model times events by counting cycles since each phase began.

module tb_duty_ramp;

    localparam int TICK_DIV   = 4;
    localparam int STEP       = 10;
    localparam int KICK_TICKS = 3;
    localparam int KICK_MIN   = 40;

    localparam int M_OFF  = 0;
    localparam int M_KICK = 1;
    localparam int M_RAMP = 2;
    localparam int M_HOLD = 3;

    logic       clk = 1'b0;
    logic       reset_p;
    logic       enable;
    logic [7:0] duty_target;
    logic [7:0] duty_out;
    logic       busy;
    logic       kick_active;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: mode, duty, and cycles elapsed since the current phase began.
    int m_mode = M_OFF;
    int m_duty = 0;
    int m_ph   = 0;

    typedef struct {
        bit    rst;
        bit    en;
        int    tgt;
        int    n;
        int    duty;
        bit    busy;
        bit    kick;
        string name;
    } vec_t;

    vec_t vecs[$];

    duty_ramp #(
        .TICK_DIV   (TICK_DIV),
        .STEP       (STEP),
        .KICK_TICKS (KICK_TICKS),
        .KICK_MIN   (KICK_MIN)
    ) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .enable      (enable),
        .duty_target (duty_target),
        .duty_out    (duty_out),
        .busy        (busy),
        .kick_active (kick_active)
    );

    always #5 clk = ~clk;

    function automatic void add(bit rst, bit en, int tgt, int n, int d, bit b, bit k, string name);
        vec_t v;
        v.rst = rst; v.en = en; v.tgt = tgt; v.n = n;
        v.duty = d; v.busy = b; v.kick = k; v.name = name;
        vecs.push_back(v);
    endfunction

    // Advance the model by one clock, using the inputs present before the edge.
    function automatic void model_step(bit rst, bit en, int tgt);
        bit tick;
        int d;
        tick = ((m_ph % TICK_DIV) == TICK_DIV - 1);
        if (rst || !en) begin
            m_mode = M_OFF; m_duty = 0; m_ph = 0;
        end else begin
            case (m_mode)
                M_OFF: begin
                    if (tgt >= KICK_MIN) begin
                        m_mode = M_KICK; m_duty = 255; m_ph = 0;
                    end else if (tgt > 0) begin
                        m_mode = M_RAMP; m_duty = 0; m_ph = 0;
                    end
                end
                M_KICK: begin
                    if (tgt == 0 || m_ph == KICK_TICKS * TICK_DIV - 1) begin
                        m_mode = M_RAMP; m_ph = 0;
                    end else begin
                        m_ph++;
                    end
                end
                M_RAMP: begin
                    if (m_duty == tgt) begin
                        m_mode = (tgt != 0) ? M_HOLD : M_OFF; m_ph = 0;
                    end else begin
                        if (tick) begin
                            d = tgt - m_duty;
                            if (d > STEP)  d = STEP;
                            if (d < -STEP) d = -STEP;
                            m_duty += d;
                        end
                        m_ph++;
                    end
                end
                default: begin
                    if (tgt != m_duty) begin
                        m_mode = M_RAMP; m_ph = 0;
                    end
                end
            endcase
        end
    endfunction

    // Drive one cycle of inputs, clock it, and compare the DUT with the model.
    task automatic run_cycle(input bit rst, input bit en, input int tgt);
        bit eb;
        bit ek;
        reset_p     = rst;
        enable      = en;
        duty_target = 8'(tgt);
        model_step(rst, en, tgt);
        @(posedge clk);
        #1;
        cyc++;
        eb = (m_mode == M_KICK) || (m_mode == M_RAMP);
        ek = (m_mode == M_KICK);
        checks++;
        if (duty_out !== 8'(m_duty) || busy !== eb || kick_active !== ek) begin
            errors++;
            $display("FAIL model cyc=%0d got duty=%0d busy=%0b kick=%0b want duty=%0d busy=%0b kick=%0b",
                     cyc, duty_out, busy, kick_active, m_duty, eb, ek);
        end
    endtask

    initial begin
        int tgt;
        bit en;
        bit rst;

        reset_p     = 1'b1;
        enable      = 1'b0;
        duty_target = 8'd0;

        // Start-up with kick, then ramp 255 -> 80.
        add(1, 0,  0,  2,   0, 0, 0, "reset");
        add(0, 1, 80,  1, 255, 1, 1, "kick_first");
        add(0, 1, 80, 11, 255, 1, 1, "kick_last");
        add(0, 1, 80,  1, 255, 1, 0, "kick_to_ramp");
        add(0, 1, 80,  3, 255, 1, 0, "ramp_wait");
        add(0, 1, 80,  1, 245, 1, 0, "ramp_step1");
        add(0, 1, 80, 64,  85, 1, 0, "ramp_85");
        add(0, 1, 80,  4,  80, 1, 0, "ramp_80");
        add(0, 1, 80,  1,  80, 0, 0, "hold_80");
        // Retarget up, including a final partial step with no overshoot.
        add(0, 1, 105,  1,  80, 1, 0, "retarget_ramp");
        add(0, 1, 105, 12, 105, 1, 0, "ramp_105");
        add(0, 1, 105,  1, 105, 0, 0, "hold_105");
        add(0, 1, 108,  1, 105, 1, 0, "retarget_108");
        add(0, 1, 108,  3, 105, 1, 0, "no_early_step");
        add(0, 1, 108,  1, 108, 1, 0, "ramp_108");
        add(0, 1, 108,  1, 108, 0, 0, "hold_108");
        // Ramp down to zero from 130 (13 ticks), then return to off.
        add(0, 1, 130,  1, 108, 1, 0, "retarget_130");
        add(0, 1, 130, 12, 130, 1, 0, "ramp_130");
        add(0, 1, 130,  1, 130, 0, 0, "hold_130");
        add(0, 1,   0,  1, 130, 1, 0, "down_start");
        add(0, 1,   0,  4, 120, 1, 0, "down_120");
        add(0, 1,   0, 48,   0, 1, 0, "down_0");
        add(0, 1,   0,  1,   0, 0, 0, "off_after_zero");
        add(0, 1,   0,  3,   0, 0, 0, "off_stays");
        // Low start: no kick.
        add(0, 1,   1,  1,   0, 1, 0, "low_start");
        add(0, 1,   1,  4,   1, 1, 0, "low_tick");
        add(0, 1,   1,  1,   1, 0, 0, "low_hold");
        // Enable drop mid-kick, then a fresh full-length kick.
        add(0, 0,   1,  1,   0, 0, 0, "disable");
        add(0, 1,  80,  1, 255, 1, 1, "kick2_first");
        add(0, 1,  80,  5, 255, 1, 1, "kick2_mid");
        add(0, 0,  80,  1,   0, 0, 0, "kick_abort");
        add(0, 1,  80,  1, 255, 1, 1, "kick3_first");
        add(0, 1,  80, 11, 255, 1, 1, "kick3_full");
        add(0, 1,  80,  1, 255, 1, 0, "kick3_end");
        // Zero target during a kick ends the kick on the next cycle.
        add(0, 0,   0,  1,   0, 0, 0, "disable2");
        add(0, 1, 200,  1, 255, 1, 1, "kick4_first");
        add(0, 1,   0,  1, 255, 1, 0, "kick_zero_end");
        add(0, 1,   0,  4, 245, 1, 0, "kick_zero_ramp");
        // Reset while duty_out is 150 in the middle of a ramp.
        add(0, 0,   0,  1,   0, 0, 0, "disable3");
        add(0, 1,  30,  1,   0, 1, 0, "low30_start");
        add(0, 1,  30, 12,  30, 1, 0, "low30_ramp");
        add(0, 1,  30,  1,  30, 0, 0, "hold_30");
        add(0, 1, 200,  1,  30, 1, 0, "retarget_200");
        add(0, 1, 200, 48, 150, 1, 0, "ramp_150");
        add(1, 1, 200,  1,   0, 0, 0, "reset_mid_ramp");
        add(0, 1, 200,  1, 255, 1, 1, "restart_kick");

        foreach (vecs[i]) begin
            for (int c = 0; c < vecs[i].n; c++) begin
                run_cycle(vecs[i].rst, vecs[i].en, vecs[i].tgt);
            end
            checks++;
            if (duty_out !== 8'(vecs[i].duty) || busy !== vecs[i].busy || kick_active !== vecs[i].kick) begin
                errors++;
                $display("FAIL vec %s got duty=%0d busy=%0b kick=%0b want duty=%0d busy=%0b kick=%0b",
                         vecs[i].name, duty_out, busy, kick_active,
                         vecs[i].duty, vecs[i].busy, vecs[i].kick);
            end
        end

        // Random stimulus: sticky targets so ramps and holds complete, plus rare disables and resets.
        tgt = 80;
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            en  = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 39) == 0) begin
                case ($urandom_range(0, 3))
                    0:       tgt = 0;
                    1:       tgt = $urandom_range(1, KICK_MIN - 1);
                    2:       tgt = 255;
                    default: tgt = $urandom_range(0, 255);
                endcase
            end
            run_cycle(rst, en, tgt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/duty_ramp.md
DUTY_RAMP -- requirements
Module: duty_ramp

Interface
REQ-001 SHALL have parameter TICK_DIV, default 100_000, meaning clk cycles per ramp tick (1 ms at 100 MHz).
REQ-002 SHALL have parameter STEP, default 5, meaning maximum duty change per tick (1..255).
REQ-003 SHALL have parameter KICK_TICKS, default 200, meaning ticks of full-duty kick-start.
REQ-004 SHALL have parameter KICK_MIN, default 40, meaning minimum start-up target that triggers a kick.
REQ-005 SHALL have port clk, input, 1 bit: the single system clock; all logic on posedge clk.
REQ-006 SHALL have port reset_p, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port enable, input, 1 bit: fan mode active and power on.
REQ-008 SHALL have port duty_target, input, 8 bits: requested duty from the mode logic (0..255).
REQ-009 SHALL have port duty_out, output, 8 bits: slew-limited duty, registered, fed to the PWM generator.
REQ-010 SHALL have port busy, output, 1 bit, registered: high in S_KICK or S_RAMP.
REQ-011 SHALL have port kick_active, output, 1 bit, registered: high only in S_KICK.

Function
REQ-012 SHALL implement states S_OFF, S_KICK, S_RAMP and S_HOLD in a registered state machine.
REQ-013 Prescaler SHALL count 0..TICK_DIV-1 and emit a one-cycle tick on wrap. It SHALL hold at 0 in S_OFF and clear on every entry into S_KICK or S_RAMP.
REQ-014 In S_OFF, duty_out SHALL be 0. When enable=1 and duty_target>=KICK_MIN, the block SHALL go to S_KICK. When enable=1 and 0<duty_target<KICK_MIN, it SHALL go to S_RAMP.
REQ-015 In S_KICK, duty_out SHALL be 255 from the first cycle. After KICK_TICKS ticks, the block SHALL go to S_RAMP with duty_out still 255.
REQ-016 In S_RAMP, on each tick duty_out SHALL move toward duty_target by min(STEP, |duty_target-duty_out|). Arithmetic SHALL use 9 bits, so results never wrap below 0 or above 255.
REQ-017 In S_RAMP, when duty_out==duty_target, the block SHALL go to S_HOLD if the value is nonzero and to S_OFF if it is zero.
REQ-018 In S_HOLD, duty_out SHALL be constant. Any change of duty_target SHALL cause a transition to S_RAMP on the next cycle.
REQ-019 A target change during S_KICK SHALL NOT abort the kick. S_RAMP SHALL use the target value sampled on each tick.
REQ-020 If duty_target==0 during S_KICK, the kick SHALL end on the next cycle and the block SHALL go to S_RAMP to ramp down to 0.
REQ-021 enable=0 SHALL take priority over all other conditions in any state: next cycle the state SHALL be S_OFF, duty_out SHALL be 0, and the prescaler and kick counter SHALL be cleared.
REQ-022 Latency: state and outputs SHALL change exactly one clk after the causing input or tick. There SHALL be no combinational path from inputs to outputs.
REQ-023 A single S_RAMP tick SHALL never change duty_out by more than STEP.

Reset
REQ-024 On reset_p=1 at posedge clk, the block SHALL set state=S_OFF, duty_out=0, busy=0, kick_active=0, prescaler=0 and kick counter=0.
REQ-025 Reset asserted mid-kick or mid-ramp SHALL behave identically to REQ-024. After release, the block SHALL restart from S_OFF.

Verification (TICK_DIV=4, STEP=10, KICK_TICKS=3, KICK_MIN=40)
REQ-026 Start-up: enable=1 with duty_target=80 -> duty_out=255 and kick_active=1 for 12 clk. Then duty_out steps 245, 235, ... , 85, 80 at 4-clk intervals, followed by S_HOLD with busy=0.
REQ-027 Low start: duty_target=1 from S_OFF -> no kick; duty_out=1 after the first tick; then S_HOLD.
REQ-028 Ramp down to zero: from S_HOLD at 130, set duty_target=0 -> duty_out steps 120...0, 13 ticks in total, then state=S_OFF.
REQ-029 Priority: enable drops mid-kick -> next cycle duty_out=0 and kick_active=0. Re-enabling then starts a fresh, full 12-clk kick.
REQ-030 Reset mid-ramp: reset_p pulse while duty_out=150 -> duty_out=0 and state=S_OFF on that edge.
REQ-031 Retarget: in S_HOLD at 105, set duty_target=108 -> duty_out=108 after one tick, with no overshoot.
